// File: rtl/ahb_register_bank.sv
// AHB-Lite slave data-phase stage: registers decoder selects at address accept,
// performs register writes/reads, and produces zero-wait OKAY or two-cycle ERROR.
module ahb_register_bank #(
    parameter int          HDATA_WIDTH     = 32,
    parameter logic [15:0] PAYLOAD_RESET   = 16'h0000,
    parameter logic [7:0]  DATA_SIZE_RESET = 8'h00
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   hsel_x,
    input  logic                   hready,
    input  logic                   hwrite,
    input  logic [2:0]             haddr,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hsize,
    input  logic [HDATA_WIDTH-1:0] hwdata,
    input  logic [1:0]             write_select,
    input  logic [1:0]             read_select,
    input  logic                   map_hresp,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [HDATA_WIDTH-1:0] hrdata,
    output logic [15:0]            payload_o,
    output logic [7:0]             data_size_o,
    output logic                   payload_wr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_hwrite;
    logic [2:0]  r_haddr;
    logic [1:0]  r_wsel;
    logic [1:0]  r_rsel;

    logic [15:0] r_payload;
    logic [7:0]  r_data_size;
    logic        r_payload_wr;
    logic [3:0]  r_err_cnt;
    logic [2:0]  r_err_addr;
    logic        r_err_dir;

    logic        w_accept;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_err_entry;
    logic        w_err_clear;
    logic [7:0]  w_err_status;
    logic        w_unused;

    // ERR1 drives hready low bus-wide, so no address phase can land there.
    assign w_accept     = hsel_x & hready & htrans[1] & (r_state != S_ERR1);
    assign w_wr_en      = (r_state == S_DATA) &  r_hwrite;
    assign w_rd_en      = (r_state == S_DATA) & ~r_hwrite;
    assign w_err_entry  = w_accept & map_hresp;
    assign w_err_clear  = w_rd_en & (r_rsel == 2'd0);
    assign w_err_status = {r_err_dir, r_err_addr, r_err_cnt};
    assign w_unused     = ^{hsize, htrans[0], hwdata[15:8], r_haddr};

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (r_state == S_ERR1) begin
            w_state_next = S_ERR2;
        end else if (w_accept) begin
            w_state_next = map_hresp ? S_ERR1 : S_DATA;
        end
    end

    always_comb begin
        hreadyout = (r_state != S_ERR1);
        hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_hwrite <= 1'b0;
            r_haddr  <= 3'd0;
            r_wsel   <= 2'd0;
            r_rsel   <= 2'd0;
        end else if (w_accept) begin
            r_hwrite <= hwrite;
            r_haddr  <= haddr;
            r_wsel   <= write_select;
            r_rsel   <= read_select;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_payload    <= PAYLOAD_RESET;
            r_data_size  <= DATA_SIZE_RESET;
            r_payload_wr <= 1'b0;
        end else begin
            r_payload_wr <= 1'b0;
            if (w_wr_en) begin
                case (r_wsel)
                    2'd0: begin
                        r_payload    <= hwdata[31:16];
                        r_payload_wr <= 1'b1;
                    end
                    2'd1: begin
                        r_payload[15:8] <= hwdata[31:24];
                        r_payload_wr    <= 1'b1;
                    end
                    2'd2:    r_data_size <= hwdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // A new error entry outranks the read-to-clear landing on the same edge.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_err_cnt  <= 4'd0;
            r_err_addr <= 3'd0;
            r_err_dir  <= 1'b0;
        end else if (w_err_entry) begin
            if (w_err_clear) begin
                r_err_cnt <= 4'd1;
            end else if (r_err_cnt != 4'hF) begin
                r_err_cnt <= r_err_cnt + 4'd1;
            end
            r_err_addr <= haddr;
            r_err_dir  <= hwrite;
        end else if (w_err_clear) begin
            r_err_cnt  <= 4'd0;
            r_err_addr <= 3'd0;
            r_err_dir  <= 1'b0;
        end
    end

    always_comb begin
        hrdata = '0;
        if (w_rd_en) begin
            case (r_rsel)
                2'd0: hrdata[15:8]  = w_err_status;
                2'd1: hrdata[31:16] = r_payload;
                2'd2: hrdata[31:24] = r_payload[15:8];
                2'd3: hrdata[7:0]   = r_data_size;
                default: ;
            endcase
        end
    end

    assign payload_o   = r_payload;
    assign data_size_o = r_data_size;
    assign payload_wr  = r_payload_wr;

endmodule

// File: tb/tb_ahb_register_bank.sv
// Bench for ahb_register_bank: directed vector table, corner sequences,
// then randomized traffic against a transfer-level reference model.
module tb_ahb_register_bank;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_x, hready, hwrite, map_hresp;
    logic [2:0]  haddr, hsize;
    logic [1:0]  htrans, write_select, read_select;
    logic [31:0] hwdata;
    logic        hreadyout, hresp, payload_wr;
    logic [31:0] hrdata;
    logic [15:0] payload_o;
    logic [7:0]  data_size_o;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    ahb_register_bank #(
        .HDATA_WIDTH    (32),
        .PAYLOAD_RESET  (16'h0000),
        .DATA_SIZE_RESET(8'h00)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel_x      (hsel_x),
        .hready      (hready),
        .hwrite      (hwrite),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .write_select(write_select),
        .read_select (read_select),
        .map_hresp   (map_hresp),
        .hreadyout   (hreadyout),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .payload_o   (payload_o),
        .data_size_o (data_size_o),
        .payload_wr  (payload_wr)
    );

    typedef struct {
        logic        sel;
        logic        rdy_in;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  addr;
        logic [1:0]  wsel;
        logic [1:0]  rsel;
        logic        map;
        logic [31:0] wdata;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic [15:0] e_pay;
        logic [7:0]  e_ds;
        logic        e_pwr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic sel, logic rdy_in, logic [1:0] trans, logic wr,
                                logic [2:0] addr, logic [1:0] wsel, logic [1:0] rsel,
                                logic map, logic [31:0] wdata, logic e_rdy, logic e_resp,
                                logic [31:0] e_rdata, logic [15:0] e_pay, logic [7:0] e_ds,
                                logic e_pwr);
        vec_t v;
        v.sel = sel; v.rdy_in = rdy_in; v.trans = trans; v.wr = wr; v.addr = addr;
        v.wsel = wsel; v.rsel = rsel; v.map = map; v.wdata = wdata;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata;
        v.e_pay = e_pay; v.e_ds = e_ds; v.e_pwr = e_pwr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rdy, input logic e_resp,
                           input logic [31:0] e_rdata, input logic [15:0] e_pay,
                           input logic [7:0] e_ds, input logic e_pwr);
        chk({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, e_rdy});
        chk({tag, ".hresp"},     {31'd0, hresp},     {31'd0, e_resp});
        chk({tag, ".hrdata"},    hrdata,             e_rdata);
        chk({tag, ".payload"},   {16'd0, payload_o}, {16'd0, e_pay});
        chk({tag, ".data_size"}, {24'd0, data_size_o}, {24'd0, e_ds});
        chk({tag, ".payload_wr"}, {31'd0, payload_wr}, {31'd0, e_pwr});
    endtask

    task automatic drive(input logic sel, input logic rdy_in, input logic [1:0] trans,
                         input logic wr, input logic [2:0] addr, input logic [1:0] wsel,
                         input logic [1:0] rsel, input logic map, input logic [31:0] wdata);
        hsel_x = sel; hready = rdy_in; htrans = trans; hwrite = wr; haddr = addr;
        write_select = wsel; read_select = rsel; map_hresp = map; hwdata = wdata;
        hsize = 3'd1;
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    // Reference model: registers plus the one outstanding transfer (kind 0 none,
    // 1 normal data phase, 2 first error cycle, 3 second error cycle).
    int          m_kind;
    logic        m_wr;
    logic [1:0]  m_wsel, m_rsel;
    logic [15:0] m_pay;
    logic [7:0]  m_ds;
    int          m_cnt;
    logic [2:0]  m_eaddr;
    logic        m_edir;
    logic        m_pwr;

    task automatic model_reset();
        m_kind = 0; m_wr = 0; m_wsel = 0; m_rsel = 0;
        m_pay = 16'h0000; m_ds = 8'h00; m_cnt = 0; m_eaddr = 0; m_edir = 0; m_pwr = 0;
    endtask

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        logic [7:0]  es;
        r = 32'd0;
        es = {m_edir, m_eaddr, 4'(m_cnt)};
        if (m_kind == 1 && !m_wr) begin
            if (m_rsel == 2'd0)      r = {16'd0, es, 8'd0};
            else if (m_rsel == 2'd1) r = {m_pay, 16'd0};
            else if (m_rsel == 2'd2) r = {m_pay[15:8], 24'd0};
            else                     r = {24'd0, m_ds};
        end
        return r;
    endfunction

    task automatic model_edge();
        logic acc, clr;
        acc = hsel_x && hready && htrans[1] && (m_kind != 2);
        clr = 1'b0;
        m_pwr = 1'b0;
        if (m_kind == 1) begin
            if (m_wr) begin
                if (m_wsel == 2'd0)      begin m_pay = hwdata[31:16]; m_pwr = 1'b1; end
                else if (m_wsel == 2'd1) begin m_pay[15:8] = hwdata[31:24]; m_pwr = 1'b1; end
                else if (m_wsel == 2'd2) m_ds = hwdata[7:0];
            end else if (m_rsel == 2'd0) begin
                clr = 1'b1;
            end
        end
        if (acc && map_hresp) begin
            m_cnt   = clr ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
            m_eaddr = haddr;
            m_edir  = hwrite;
        end else if (clr) begin
            m_cnt = 0; m_eaddr = 0; m_edir = 0;
        end
        if (m_kind == 2) begin
            m_kind = 3;
        end else if (acc) begin
            m_kind = map_hresp ? 2 : 1;
            m_wr = hwrite; m_wsel = write_select; m_rsel = read_select;
            $display("rand accept t=%0t wr=%0d addr=%0d err=%0d", $time, hwrite, haddr, map_hresp);
        end else begin
            m_kind = 0;
        end
    endtask

    initial begin
        vecs[0]  = mk(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0,        1,0,32'h0,        16'h0000,8'h00,0);
        vecs[1]  = mk(1,1,2'd2,1,3'd2,2'd0,2'd0,0,32'h0,        1,0,32'h0,        16'h0000,8'h00,0);
        vecs[2]  = mk(1,1,2'd2,0,3'd2,2'd3,2'd1,0,32'hBEEF_0000,1,0,32'h0,        16'h0000,8'h00,0);
        vecs[3]  = mk(1,1,2'd2,1,3'd3,2'd1,2'd0,0,32'h0,        1,0,32'hBEEF_0000,16'hBEEF,8'h00,1);
        vecs[4]  = mk(1,1,2'd2,1,3'd4,2'd2,2'd0,0,32'h5A00_0000,1,0,32'h0,        16'hBEEF,8'h00,0);
        vecs[5]  = mk(1,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0000_0010,1,0,32'h0,        16'h5AEF,8'h00,1);
        vecs[6]  = mk(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0,        1,0,32'h0,        16'h5AEF,8'h10,0);
        vecs[7]  = mk(1,1,2'd2,1,3'd1,2'd3,2'd0,1,32'h0,        1,0,32'h0,        16'h5AEF,8'h10,0);
        vecs[8]  = mk(1,0,2'd2,1,3'd1,2'd0,2'd0,0,32'hFFFF_FFFF,0,1,32'h0,        16'h5AEF,8'h10,0);
        vecs[9]  = mk(1,1,2'd2,0,3'd1,2'd3,2'd0,0,32'hFFFF_FFFF,1,1,32'h0,        16'h5AEF,8'h10,0);
        vecs[10] = mk(1,1,2'd2,0,3'd1,2'd3,2'd0,0,32'h0,        1,0,32'h0000_9100,16'h5AEF,8'h10,0);
        vecs[11] = mk(1,1,2'd1,1,3'd2,2'd0,2'd0,0,32'h0,        1,0,32'h0,        16'h5AEF,8'h10,0);
        vecs[12] = mk(1,1,2'd0,1,3'd2,2'd0,2'd0,0,32'h1234_0000,1,0,32'h0,        16'h5AEF,8'h10,0);
        vecs[13] = mk(0,1,2'd2,1,3'd2,2'd0,2'd0,0,32'h1234_0000,1,0,32'h0,        16'h5AEF,8'h10,0);
        vecs[14] = mk(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h1234_0000,1,0,32'h0,        16'h5AEF,8'h10,0);

        hresetn = 1'b0;
        drive(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0);
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;

        // Directed table: each row is one cycle; expectations are the outputs seen in it.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].sel, vecs[i].rdy_in, vecs[i].trans, vecs[i].wr, vecs[i].addr,
                  vecs[i].wsel, vecs[i].rsel, vecs[i].map, vecs[i].wdata);
            @(negedge hclk);
            $display("vec %0d: rdy=%0d resp=%0d rdata=%08h payload=%04h ds=%02h pwr=%0d",
                     i, hreadyout, hresp, hrdata, payload_o, data_size_o, payload_wr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_rdata,
                    vecs[i].e_pay, vecs[i].e_ds, vecs[i].e_pwr);
            next_cycle();
        end

        // 16 back-to-back errored reads to haddr 7: count saturates.
        for (int i = 0; i < 16; i++) begin
            drive(1,1,2'd2,0,3'd7,2'd3,2'd0,1,32'h0);
            next_cycle();
            drive(1,0,2'd2,0,3'd7,2'd3,2'd0,0,32'h0);
            @(negedge hclk);
            chk($sformatf("sat_err%0d.hreadyout", i), {31'd0, hreadyout}, 32'd0);
            next_cycle();
        end
        drive(1,1,2'd2,0,3'd1,2'd3,2'd0,0,32'h0);
        @(negedge hclk);
        chk("sat_err2.hresp", {31'd0, hresp}, 32'd1);
        next_cycle();
        drive(1,1,2'd2,0,3'd7,2'd3,2'd0,1,32'h0);
        @(negedge hclk);
        $display("sat read: rdata=%08h", hrdata);
        chk("sat_read.hrdata", hrdata, 32'h0000_7F00);
        next_cycle();
        drive(1,0,2'd2,0,3'd0,2'd3,2'd0,0,32'h0);
        @(negedge hclk);
        chk("clr_err1.hreadyout", {31'd0, hreadyout}, 32'd0);
        chk("clr_err1.hresp", {31'd0, hresp}, 32'd1);
        next_cycle();
        drive(1,1,2'd2,0,3'd1,2'd3,2'd0,0,32'h0);
        next_cycle();
        drive(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0);
        @(negedge hclk);
        $display("clear-collide read: rdata=%08h", hrdata);
        chk("clr_collide.hrdata", hrdata, 32'h0000_7100);
        next_cycle();

        // Reset asserted while in the first error cycle.
        drive(1,1,2'd2,1,3'd5,2'd3,2'd0,1,32'h0);
        next_cycle();
        drive(0,0,2'd0,0,3'd0,2'd3,2'd0,0,32'h0);
        @(negedge hclk);
        chk("rst_err1.pre_hreadyout", {31'd0, hreadyout}, 32'd0);
        #1 hresetn = 1'b0;
        #1;
        $display("reset in ERR1: rdy=%0d resp=%0d", hreadyout, hresp);
        chk("rst_err1.hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst_err1.hresp", {31'd0, hresp}, 32'd0);
        chk("rst_err1.payload", {16'd0, payload_o}, 32'd0);
        next_cycle();
        hresetn = 1'b1;
        drive(1,1,2'd2,0,3'd1,2'd3,2'd0,0,32'h0);
        next_cycle();
        drive(0,1,2'd0,0,3'd0,2'd3,2'd0,0,32'h0);
        @(negedge hclk);
        chk("rst_err1.err_status", hrdata, 32'h0);
        next_cycle();

        // Randomized traffic against the reference model.
        hresetn = 1'b0;
        next_cycle();
        hresetn = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            hsel_x       = ($urandom_range(0, 3) != 0);
            hready       = (m_kind == 2) ? 1'b0 : ($urandom_range(0, 7) != 0);
            htrans       = 2'($urandom_range(0, 3));
            hwrite       = 1'($urandom_range(0, 1));
            haddr        = 3'($urandom_range(0, 7));
            hsize        = 3'($urandom_range(0, 2));
            write_select = 2'($urandom_range(0, 3));
            read_select  = 2'($urandom_range(0, 3));
            map_hresp    = ($urandom_range(0, 5) == 0);
            hwdata       = $urandom;
            @(negedge hclk);
            chk_all($sformatf("rand%0d", c), (m_kind != 2), (m_kind >= 2), model_rdata(),
                    m_pay, m_ds, m_pwr);
            @(posedge hclk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
